// File: rtl/axis_uart_rx.sv
// UART serial receiver presenting each received frame on a one-entry AXI-Stream master port.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority decision around each bit mid-point.
module axis_uart_rx #(
  parameter int DATA_WIDTH    = 8,
  parameter int DIVIDER_WIDTH = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     rx_reset_i,
  input  logic                     uart_rx_i,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     parity_err_o,
  output logic                     frame_err_o,
  output logic                     overrun_o
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    WAIT   = 3'd5
  } state_t;

  state_t                   state;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     rxs;
  logic [DIVIDER_WIDTH-1:0] neff;
  logic [DIVIDER_WIDTH-1:0] neff_in;
  logic [DIVIDER_WIDTH-1:0] cnt;
  logic [DIVIDER_WIDTH-1:0] start_pt;
  logic [DIVIDER_WIDTH-1:0] bit_pt;
  logic [BCW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]    shreg;
  logic                     par_odd;
  logic                     bit_val;
  logic                     exp_par;

  assign rxs     = sync_q[SYNC_STAGES-1];
  assign neff_in = (clk_divider_i < DIVIDER_WIDTH'(4)) ? DIVIDER_WIDTH'(4) : clk_divider_i;
  assign bit_pt  = neff - DIVIDER_WIDTH'(1);
  assign exp_par = par_odd ? ~^shreg : ^shreg;

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Two previous rxs values; the decision lands one cycle after the nominal mid-point.
  logic [1:0] hist;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hist <= 2'b11;
    end else if (rx_reset_i) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rxs};
    end
  end

  assign bit_val  = (rxs & hist[0]) | (rxs & hist[1]) | (hist[0] & hist[1]);
  assign start_pt = neff >> 1;
`else
  assign bit_val  = rxs;
  assign start_pt = (neff >> 1) - DIVIDER_WIDTH'(1);
`endif

  // Handshake: a byte transfers on any rising edge with m_axis_tvalid_o & m_axis_tready_i
  // high; tvalid never drops and tdata never changes before that transfer.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state           <= IDLE;
      sync_q          <= '1;
      neff            <= DIVIDER_WIDTH'(4);
      cnt             <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      par_odd         <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      parity_err_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
    end else if (rx_reset_i) begin
      state           <= IDLE;
      sync_q          <= '1;
      neff            <= DIVIDER_WIDTH'(4);
      cnt             <= '0;
      bit_cnt         <= '0;
      shreg           <= '0;
      par_odd         <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tvalid_o <= 1'b0;
      parity_err_o    <= 1'b0;
      frame_err_o     <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        m_axis_tvalid_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rxs) begin
            neff  <= neff_in;
            state <= START;
          end
        end

        START: begin
          if (cnt == start_pt) begin
            cnt   <= '0;
            state <= bit_val ? IDLE : DATA;
          end else begin
            cnt <= cnt + DIVIDER_WIDTH'(1);
          end
        end

        DATA: begin
          if (cnt == bit_pt) begin
            cnt     <= '0;
            shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + BCW'(1);
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              // Parity mode is captured here so a later register write cannot split a frame.
              if (parity_odd_i || parity_even_i) begin
                par_odd <= parity_odd_i;
                state   <= PARITY;
              end else begin
                state <= STOP;
              end
            end
          end else begin
            cnt <= cnt + DIVIDER_WIDTH'(1);
          end
        end

        PARITY: begin
          if (cnt == bit_pt) begin
            cnt <= '0;
            if (bit_val != exp_par) begin
              parity_err_o <= 1'b1;
            end
            state <= STOP;
          end else begin
            cnt <= cnt + DIVIDER_WIDTH'(1);
          end
        end

        STOP: begin
          if (cnt == bit_pt) begin
            cnt <= '0;
            if (bit_val) begin
              if (!m_axis_tvalid_o || m_axis_tready_i) begin
                m_axis_tdata_o  <= shreg;
                m_axis_tvalid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT;
            end
          end else begin
            cnt <= cnt + DIVIDER_WIDTH'(1);
          end
        end

        WAIT: begin
          // A held-low (break) line must return high before a new start is accepted.
          cnt <= '0;
          if (rxs) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_rx.sv
// Self-checking bench for axis_uart_rx: frame driver, byte scoreboard with a forked monitor.
module tb_axis_uart_rx;

  logic        clk;
  logic        arstn_i;
  logic [31:0] clk_divider;
  logic        parity_odd;
  logic        parity_even;
  logic        rx_reset;
  logic        uart_rx;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        parity_err;
  logic        frame_err;
  logic        overrun;

  int          n_checks;
  int          n_fail;
  int          frame_seen;
  int          ovr_seen;
  int          tv_cycles;
  int          exp_frame;
  int          exp_ovr;
  logic        pe_exp;
  logic [7:0]  exp_q[$];

  axis_uart_rx dut (
    .clk_i           (clk),
    .arstn_i         (arstn_i),
    .clk_divider_i   (clk_divider),
    .parity_odd_i    (parity_odd),
    .parity_even_i   (parity_even),
    .rx_reset_i      (rx_reset),
    .uart_rx_i       (uart_rx),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .parity_err_o    (parity_err),
    .frame_err_o     (frame_err),
    .overrun_o       (overrun)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    uart_rx = v;
    repeat (n) tick();
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // pmode: 0 none, 1 odd, 2 even. The model is updated before the stop bit goes out so
  // the expectation is already queued when the DUT presents the byte.
  task automatic send_frame(input logic [7:0] d, input int n, input int pmode,
                            input bit pflip, input bit stop_bit);
    logic p;
    parity_odd  = (pmode == 1);
    parity_even = (pmode == 2);
    if (pmode != 0 && pflip) pe_exp = 1'b1;
    if (stop_bit) begin
      if (!tready && exp_q.size() > 0) exp_ovr++;
      else exp_q.push_back(d);
    end else begin
      exp_frame++;
    end
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(d[i], n);
    if (pmode != 0) begin
      p = (pmode == 1) ? ~^d : ^d;
      drive_bit(p ^ pflip, n);
    end
    drive_bit(stop_bit, n);
  endtask

  task automatic monitor();
    logic       prev_tv;
    logic       prev_hs;
    logic [7:0] prev_d;
    prev_tv = 1'b0;
    prev_hs = 1'b0;
    prev_d  = '0;
    forever begin
      @(negedge clk);
      if (arstn_i && !rx_reset) begin
        if (prev_tv && !prev_hs && tvalid) check("tdata_stable", tdata, prev_d);
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", tdata);
          end else begin
            check("tdata", tdata, exp_q.pop_front());
          end
        end
        if (frame_err) frame_seen++;
        if (overrun) ovr_seen++;
        if (tvalid) tv_cycles++;
      end
      prev_tv = tvalid;
      prev_hs = tvalid & tready;
      prev_d  = tdata;
    end
  endtask

  initial begin
    int         tv0;
    int         n;
    int         pm;
    logic [7:0] d;
    n_checks = 0; n_fail = 0; frame_seen = 0; ovr_seen = 0; tv_cycles = 0;
    exp_frame = 0; exp_ovr = 0; pe_exp = 1'b0;
    arstn_i = 1'b0; rx_reset = 1'b0; uart_rx = 1'b1; tready = 1'b1;
    clk_divider = 32'd16; parity_odd = 1'b0; parity_even = 1'b0;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    arstn_i = 1'b1;
    idle(10);

    // basic byte, exactly one tvalid cycle
    tv0 = tv_cycles;
    send_frame(8'hA5, 16, 0, 0, 1);
    idle(12);
    check("a5_tvalid_cycles", tv_cycles - tv0, 1);
    check("a5_parity_err", parity_err, 0);
    check("a5_frame_cnt", frame_seen, 0);
    check("a5_ovr_cnt", ovr_seen, 0);

    // randomized frames with correct parity
    for (int k = 0; k < 8; k++) begin
      n  = $urandom_range(4, 20);
      pm = $urandom_range(0, 2);
      d  = 8'($urandom_range(0, 255));
      clk_divider = 32'(n);
      send_frame(d, n, pm, 0, 1);
      idle(n + 6);
      check("rand_parity_err", parity_err, pe_exp);
    end
    check("rand_drained", exp_q.size(), 0);

    // bad odd parity: byte delivered, error sticky until soft reset
    clk_divider = 32'd16;
    send_frame(8'h3C, 16, 1, 1, 1);
    idle(12);
    check("par_err_set", parity_err, 1);
    idle(50);
    check("par_err_held", parity_err, 1);
    rx_reset = 1'b1;
    tick();
    rx_reset = 1'b0;
    pe_exp = 1'b0;
    check("par_err_cleared", parity_err, 0);
    parity_odd = 1'b0;
    idle(5);

    // framing error, held-low line, then recovery
    send_frame(8'h55, 16, 0, 0, 0);
    drive_bit(1'b0, 40);
    check("frame_err_cnt", frame_seen, exp_frame);
    check("frame_no_tvalid", tvalid, 0);
    idle(10);
    send_frame(8'h12, 16, 0, 0, 1);
    idle(12);
    check("after_break_drained", exp_q.size(), 0);

    // overrun with a stalled consumer
    tready = 1'b0;
    send_frame(8'h11, 16, 0, 0, 1);
    idle(12);
    send_frame(8'h22, 16, 0, 0, 1);
    idle(12);
    check("ovr_tvalid", tvalid, 1);
    check("ovr_tdata_held", tdata, 8'h11);
    check("ovr_cnt", ovr_seen, exp_ovr);
    tready = 1'b1;
    idle(4);
    check("ovr_drained", exp_q.size(), 0);
    check("ovr_tvalid_low", tvalid, 0);

    // false start, then divider below the minimum
    tv0 = tv_cycles;
    drive_bit(1'b0, 3);
    idle(40);
    check("false_start_tv", tv_cycles - tv0, 0);
    check("false_start_fe", frame_seen, exp_frame);
    clk_divider = 32'd2;
    send_frame(8'h81, 4, 0, 0, 1);
    idle(10);
    check("div2_drained", exp_q.size(), 0);

    // asynchronous reset mid-frame with a byte pending
    clk_divider = 32'd16;
    tready = 1'b0;
    send_frame(8'h5A, 16, 0, 0, 1);
    idle(12);
    check("pend_tvalid", tvalid, 1);
    d = 8'hC3;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 3; i++) drive_bit(d[i], 16);
    arstn_i = 1'b0;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_tdata", tdata, 0);
    check("arst_parity_err", parity_err, 0);
    exp_q.delete();
    uart_rx = 1'b1;
    repeat (3) tick();
    arstn_i = 1'b1;
    tready = 1'b1;
    idle(8);
    send_frame(8'hF0, 16, 0, 0, 1);
    idle(12);
    check("after_arst_drained", exp_q.size(), 0);

`ifdef UART_RX_MAJORITY_VOTE_EN
    // single-cycle glitch at the mid-point of data bit 3
    d = 8'h5A;
    exp_q.push_back(d);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        drive_bit(d[i], 8);
        drive_bit(~d[i], 1);
        drive_bit(d[i], 7);
      end else begin
        drive_bit(d[i], 16);
      end
    end
    drive_bit(1'b1, 16);
    idle(12);
    check("glitch_drained", exp_q.size(), 0);
`endif

    // final report
    check("final_queue", exp_q.size(), 0);
    check("final_frame_cnt", frame_seen, exp_frame);
    check("final_ovr_cnt", ovr_seen, exp_ovr);
    check("final_parity_err", parity_err, pe_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
